// File: rtl/sample_sequencer_if.sv
// Signal bundle between the sample sequencer and the audio path
// (spi2adc, var_delay, spi2dac/pwm). The master side is the sequencer.
interface sample_sequencer_if #(
    parameter int DW   = 10,
    parameter int DLYW = 9
);
    logic            enable;
    logic            clr_status;
    logic [DLYW-1:0] delay_sw;
    logic            adc_start;
    logic            adc_valid;
    logic [DW-1:0]   adc_data;
    logic            proc_en;
    logic [DW-1:0]   proc_data;
    logic [DLYW-1:0] proc_delay;
    logic [DW-1:0]   proc_result;
    logic            dac_start;
    logic [DW-1:0]   dac_data;
    logic            busy;
    logic            overrun;
    logic [7:0]      timeout_cnt;

    modport master (
        input  enable, clr_status, delay_sw, adc_valid, adc_data, proc_result,
        output adc_start, proc_en, proc_data, proc_delay, dac_start, dac_data,
               busy, overrun, timeout_cnt
    );

    modport slave (
        output enable, clr_status, delay_sw, adc_valid, adc_data, proc_result,
        input  adc_start, proc_en, proc_data, proc_delay, dac_start, dac_data,
               busy, overrun, timeout_cnt
    );
endinterface

// File: rtl/sample_sequencer.sv
// Per-sample scheduler: sample tick -> ADC start -> var_delay strobe -> DAC load.
// Recovers from a missing ADC result by reusing the previous sample, and
// flags ticks that land while a frame is still in flight.
//
//  state       | meaning
//  ------------+------------------------------------------------------------
//  ST_IDLE     | waiting for the sample tick (dac_start may be pulsing here)
//  ST_WAIT_ADC | conversion started, waiting for adc_valid or timeout
//  ST_PROC     | var_delay computing; dac_data loaded on terminal count
module sample_sequencer #(
    parameter int DIV         = 5000,
    parameter int ADC_TIMEOUT = 2000,
    parameter int PROC_CYCLES = 4,
    parameter int DW          = 10,
    parameter int DLYW        = 9
) (
    input  logic                sysclk,
    input  logic                rst_n,
    sample_sequencer_if.master  bus
);

    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TMAX = (ADC_TIMEOUT > PROC_CYCLES) ? ADC_TIMEOUT : PROC_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ADC = 2'd1,
        ST_PROC     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            adc_start_q, adc_start_d;
    logic            proc_en_q, proc_en_d;
    logic            dac_start_q, dac_start_d;
    logic [DW-1:0]   proc_data_q, proc_data_d;
    logic [DLYW-1:0] proc_delay_q, proc_delay_d;
    logic [DW-1:0]   dac_data_q, dac_data_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      timeout_cnt_q, timeout_cnt_d;

    logic tick;
    logic wait_done;
    logic adc_timeout;

    // The wait window is the ADC_TIMEOUT cycles following the start strobe,
    // so the timer is held during the strobe cycle itself.
    assign tick        = (cnt_q == CW'(DIV - 1));
    assign wait_done   = !adc_start_q && (tmr_q == '0);
    assign adc_timeout = (state_q == ST_WAIT_ADC) && !bus.adc_valid && wait_done;

    // Free-running sample period counter, independent of enable.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // State register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; adc_valid takes priority over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (tick && bus.enable)             state_d = ST_WAIT_ADC;
            ST_WAIT_ADC: if (bus.adc_valid || wait_done)     state_d = ST_PROC;
            ST_PROC:     if (tmr_q == '0)                    state_d = ST_IDLE;
            default:                                         state_d = ST_IDLE;
        endcase
    end

    // Output, timer, slew and status next-values; all outputs are registered.
    always_comb begin
        adc_start_d   = 1'b0;
        proc_en_d     = 1'b0;
        dac_start_d   = 1'b0;
        tmr_d         = tmr_q;
        proc_data_d   = proc_data_q;
        proc_delay_d  = proc_delay_q;
        dac_data_d    = dac_data_q;

        case (state_q)
            ST_IDLE: begin
                if (tick && bus.enable) begin
                    adc_start_d = 1'b1;
                    tmr_d       = TW'(ADC_TIMEOUT - 1);
                end
            end
            ST_WAIT_ADC: begin
                if (bus.adc_valid || wait_done) begin
                    proc_en_d = 1'b1;
                    tmr_d     = TW'(PROC_CYCLES);
                    if (bus.adc_valid) begin
                        proc_data_d = bus.adc_data;
                    end
                    if (proc_delay_q < bus.delay_sw) begin
                        proc_delay_d = proc_delay_q + DLYW'(1);
                    end else if (proc_delay_q > bus.delay_sw) begin
                        proc_delay_d = proc_delay_q - DLYW'(1);
                    end
                end else if (!adc_start_q) begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_PROC: begin
                if (tmr_q == '0) begin
                    dac_data_d  = bus.proc_result;
                    dac_start_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                tmr_d = '0;
            end
        endcase

        // Set/increment beats a coincident clear.
        overrun_d = overrun_q;
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (bus.clr_status) begin
            overrun_d = 1'b0;
        end

        timeout_cnt_d = timeout_cnt_q;
        if (adc_timeout) begin
            if (timeout_cnt_q != 8'hFF) begin
                timeout_cnt_d = timeout_cnt_q + 8'd1;
            end
        end else if (bus.clr_status) begin
            timeout_cnt_d = 8'd0;
        end
    end

    // Datapath and registered-output flops.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            tmr_q         <= '0;
            adc_start_q   <= 1'b0;
            proc_en_q     <= 1'b0;
            dac_start_q   <= 1'b0;
            proc_data_q   <= '0;
            proc_delay_q  <= '0;
            dac_data_q    <= '0;
            overrun_q     <= 1'b0;
            timeout_cnt_q <= 8'd0;
        end else begin
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            adc_start_q   <= adc_start_d;
            proc_en_q     <= proc_en_d;
            dac_start_q   <= dac_start_d;
            proc_data_q   <= proc_data_d;
            proc_delay_q  <= proc_delay_d;
            dac_data_q    <= dac_data_d;
            overrun_q     <= overrun_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign bus.adc_start   = adc_start_q;
    assign bus.proc_en     = proc_en_q;
    assign bus.dac_start   = dac_start_q;
    assign bus.proc_data   = proc_data_q;
    assign bus.proc_delay  = proc_delay_q;
    assign bus.dac_data    = dac_data_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.overrun     = overrun_q;
    assign bus.timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: instance A (DIV=50) covers frames,
// timeout, slew, enable and reset; instance B (DIV=10) covers overrun.
module tb_sample_sequencer;

    localparam int DW   = 10;
    localparam int DLYW = 9;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    sample_sequencer_if #(.DW(DW), .DLYW(DLYW)) bus_a ();
    sample_sequencer_if #(.DW(DW), .DLYW(DLYW)) bus_b ();

    sample_sequencer #(
        .DIV(50), .ADC_TIMEOUT(20), .PROC_CYCLES(4), .DW(DW), .DLYW(DLYW)
    ) u_dut_a (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus_a.master)
    );

    sample_sequencer #(
        .DIV(10), .ADC_TIMEOUT(20), .PROC_CYCLES(4), .DW(DW), .DLYW(DLYW)
    ) u_dut_b (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus_b.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    function automatic logic strobe(input int sel);
        case (sel)
            0:       return bus_a.adc_start;
            1:       return bus_a.proc_en;
            2:       return bus_a.dac_start;
            3:       return bus_b.adc_start;
            4:       return bus_b.proc_en;
            default: return bus_b.dac_start;
        endcase
    endfunction

    function automatic int any_strobe_a();
        return int'(bus_a.adc_start | bus_a.proc_en | bus_a.dac_start);
    endfunction

    // Steps at least one cycle, then until the selected strobe is seen or the budget runs out.
    task automatic wait_strobe(input int sel, input int budget, input string tag);
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (!strobe(sel) && k < budget);
        check(tag, 32'(strobe(sel)), 32'd1);
    endtask

    initial begin
        int a;
        int a_last;
        int r;
        int n;
        int exp_dly [7];
        exp_dly = '{1, 2, 3, 3, 2, 1, 0};

        bus_a.enable = 1'b0; bus_a.clr_status = 1'b0; bus_a.delay_sw = '0;
        bus_a.adc_valid = 1'b0; bus_a.adc_data = '0; bus_a.proc_result = 10'h2AA;
        bus_b.enable = 1'b0; bus_b.clr_status = 1'b0; bus_b.delay_sw = '0;
        bus_b.adc_valid = 1'b0; bus_b.adc_data = '0; bus_b.proc_result = 10'h0AA;

        // Reset state
        step(3);
        check("rst_busy",      32'(bus_a.busy),        32'd0);
        check("rst_strobes",   32'(any_strobe_a()),    32'd0);
        check("rst_proc_data", 32'(bus_a.proc_data),   32'd0);
        check("rst_delay",     32'(bus_a.proc_delay),  32'd0);
        check("rst_dac_data",  32'(bus_a.dac_data),    32'd0);
        check("rst_overrun",   32'(bus_a.overrun),     32'd0);
        check("rst_timeouts",  32'(bus_a.timeout_cnt), 32'd0);
        rst_n = 1'b1;

        // Overrun on B: adc_valid 8 cycles after adc_start, next tick lands in PROC
        bus_b.enable = 1'b1;
        wait_strobe(3, 20, "b_first_adc_start");
        step(8);
        bus_b.adc_valid = 1'b1;
        bus_b.adc_data  = 10'h0F0;
        step(1);
        bus_b.adc_valid = 1'b0;
        check("b_proc_en",   32'(bus_b.proc_en),   32'd1);
        check("b_proc_data", 32'(bus_b.proc_data), 32'h0F0);
        step(1);
        check("b_overrun_set", 32'(bus_b.overrun), 32'd1);
        check("b_busy",        32'(bus_b.busy),    32'd1);
        n = 0;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            n += int'(bus_b.adc_start);
            if (i == 4) begin
                check("b_dac_start", 32'(bus_b.dac_start), 32'd1);
                check("b_dac_data",  32'(bus_b.dac_data),  32'h0AA);
            end
        end
        check("b_no_start_while_busy", 32'(n), 32'd0);
        step(1);
        check("b_start_after_drop", 32'(bus_b.adc_start), 32'd1);
        bus_b.enable = 1'b0;
        wait_strobe(5, 40, "b_timeout_frame_dac");
        check("b_timeouts",    32'(bus_b.timeout_cnt), 32'd1);
        check("b_overrun_hold", 32'(bus_b.overrun),    32'd1);
        bus_b.clr_status = 1'b1;
        step(1);
        bus_b.clr_status = 1'b0;
        check("b_overrun_clr",  32'(bus_b.overrun),     32'd0);
        check("b_timeouts_clr", 32'(bus_b.timeout_cnt), 32'd0);

        // Normal frame on A
        bus_a.enable = 1'b1;
        wait_strobe(0, 60, "a_first_adc_start");
        a = cyc;
        step(10);
        check("a_no_early_proc_en", 32'(bus_a.proc_en), 32'd0);
        bus_a.adc_valid = 1'b1;
        bus_a.adc_data  = 10'h155;
        step(1);
        bus_a.adc_valid = 1'b0;
        check("a_proc_en",   32'(bus_a.proc_en),    32'd1);
        check("a_proc_data", 32'(bus_a.proc_data),  32'h155);
        check("a_delay_hold", 32'(bus_a.proc_delay), 32'd0);
        step(4);
        check("a_no_early_dac", 32'(bus_a.dac_start), 32'd0);
        step(1);
        check("a_dac_start", 32'(bus_a.dac_start), 32'd1);
        check("a_dac_data",  32'(bus_a.dac_data),  32'h2AA);
        step(1);
        check("a_dac_one_cycle", 32'(bus_a.dac_start),   32'd0);
        check("a_idle_after",    32'(bus_a.busy),        32'd0);
        check("a_no_timeout",    32'(bus_a.timeout_cnt), 32'd0);

        // Timeout frames with delay slew 0 -> 3 -> 0
        bus_a.delay_sw = 9'd3;
        for (int f = 0; f < 7; f++) begin
            wait_strobe(0, 60, "a_timeout_adc_start");
            if (f == 0) check("a_period", 32'(cyc - a), 32'd50);
            a = cyc;
            if (f == 4) bus_a.delay_sw = 9'd0;
            wait_strobe(1, 30, "a_timeout_proc_en");
            check("a_timeout_latency", 32'(cyc - a),          32'd21);
            check("a_slew_delay",      32'(bus_a.proc_delay), 32'(exp_dly[f]));
            check("a_data_reused",     32'(bus_a.proc_data),  32'h155);
            check("a_timeout_count",   32'(bus_a.timeout_cnt), 32'(f + 1));
        end

        // adc_valid on the last cycle of the window beats the timeout
        wait_strobe(0, 60, "a_edge_adc_start");
        step(20);
        bus_a.adc_valid = 1'b1;
        bus_a.adc_data  = 10'h0C3;
        step(1);
        bus_a.adc_valid = 1'b0;
        check("a_edge_proc_en",   32'(bus_a.proc_en),     32'd1);
        check("a_edge_proc_data", 32'(bus_a.proc_data),   32'h0C3);
        check("a_edge_no_timeout", 32'(bus_a.timeout_cnt), 32'd7);

        // Saturation: 300 timeouts in total
        for (int f = 0; f < 293; f++) begin
            wait_strobe(1, 60, "a_sat_proc_en");
        end
        check("a_timeout_sat", 32'(bus_a.timeout_cnt), 32'd255);
        check("a_delay_floor", 32'(bus_a.proc_delay),  32'd0);

        // enable dropped mid-frame: frame completes, then nothing for 5 periods
        wait_strobe(0, 60, "a_en_adc_start");
        a_last = cyc;
        bus_a.enable = 1'b0;
        wait_strobe(2, 40, "a_en_frame_completes");
        n = 0;
        for (int i = 0; i < 250; i++) begin
            step(1);
            n += any_strobe_a();
        end
        check("a_disabled_strobes", 32'(n), 32'd0);
        bus_a.enable = 1'b1;
        wait_strobe(0, 60, "a_reenable_start");
        check("a_reenable_on_tick", 32'((cyc - a_last) % 50), 32'd0);

        // Reset in WAIT_ADC
        step(3);
        check("a_busy_wait", 32'(bus_a.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("a_rst_busy",      32'(bus_a.busy),        32'd0);
        check("a_rst_proc_data", 32'(bus_a.proc_data),   32'd0);
        check("a_rst_timeouts",  32'(bus_a.timeout_cnt), 32'd0);
        check("a_rst_dac_data",  32'(bus_a.dac_data),    32'd0);
        repeat (3) @(posedge sysclk);
        #1;
        check("a_rst_strobes", 32'(any_strobe_a()), 32'd0);
        rst_n = 1'b1;
        r = cyc;
        n = 0;
        for (int i = 0; i < 49; i++) begin
            step(1);
            n += any_strobe_a();
        end
        check("a_post_rst_quiet", 32'(n), 32'd0);
        step(1);
        check("a_post_rst_start", 32'(bus_a.adc_start), 32'd1);
        check("a_post_rst_delay", 32'(cyc - r),         32'd50);
        check("a_never_overrun",  32'(bus_a.overrun),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
